pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the pipelined CPU. Generalises the fixed IF/ID latch (IR + PC4, enable, reset).
- Adds configurable field widths, sideband payload, valid/ready handshake, optional 1-entry skid buffer, flush with bubble injection and a stall-cycle counter.
- Instantiated between any two stages (F/D, D/E, E/M, M/W).

Parameters:
- IR_W, 32, instruction field width
- PC_W, 32, PC/PC4 field width
- EXT_W, 8, sideband width (exception code, delay-slot flag, etc.)
- NOP, 0, IR value driven when the stage holds a bubble
- SKID, 1, 1 = 2-entry (output + skid) with registered in_ready; 0 = single register with combinational in_ready
- CNT_W, 16, stall counter width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard all held and incoming entries this cycle
- in_valid  input  1  upstream offers an entry
- in_ready  output  1  stage can accept this cycle
- in_ir  input  IR_W  instruction
- in_pc  input  PC_W  PC4 of the instruction
- in_ext  input  EXT_W  sideband
- out_valid  output  1  out_ir/out_pc/out_ext hold a real entry
- out_ready  input  1  downstream consumes the entry this cycle
- out_ir  output  IR_W  registered instruction; NOP when empty
- out_pc  output  PC_W  registered PC4; 0 when empty
- out_ext  output  EXT_W  registered sideband; 0 when empty
- occupancy  output  2  entries held (0..2; max 1 when SKID=0)
- stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Single clock. Every state change happens on the rising edge of clk.
- Reset (priority 1):
  - out_valid=0, out_ir=NOP, out_pc=0, out_ext=0.
  - Skid entry empty, occupancy=0, stall_cnt=0.
  - Accepts during reset are discarded.
- Definitions: accept = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready:
  - SKID=1: in_ready = !skid_valid, driven from a register with no combinational path from out_ready. Equals 1 during and after reset.
  - SKID=0: in_ready = !out_valid | out_ready.
- Flush (priority 2, below reset):
  - Output and skid registers are emptied: out_valid=0, out_ir=NOP, out_pc=0, out_ext=0.
  - Any entry accepted in the same cycle is discarded.
  - stall_cnt is unaffected.
- Normal update (no reset, no flush), SKID=1:
  - Output empty or pop:
    - If skid full: output ← skid and skid empties. If accept also occurs, the incoming entry goes to skid.
    - Else if accept: output ← incoming.
    - Else: output becomes empty (NOP/0/0).
  - Output full and no pop:
    - If accept: skid ← incoming. This is legal only while the skid is empty, which in_ready guarantees.
- Normal update, SKID=0:
  - Output empty or pop: output ← incoming if accept, else empty.
  - Otherwise the output holds.
- Ordering:
  - Strict FIFO. No entry is duplicated or dropped except by flush or reset.
  - Zero-bubble throughput: with out_ready=1 held, one entry passes per cycle with 1-cycle latency.
- Hold: while out_valid=1 and out_ready=0, out_ir/out_pc/out_ext stay stable.
- occupancy: out_valid + skid_valid, registered.
- stall_cnt: increments by 1 each cycle with out_valid & !out_ready, saturates at 2^CNT_W−1, cleared only by reset.
- Unused legacy enable style: an upstream stall is expressed as in_valid=0 or in_ready=0. There is no separate enable port.

Test Plan:
- Reset then stream IR=0x1000_0001..0x1000_0005, PC=0x3004..0x3014, out_ready=1 → each appears on out_ir one cycle after its accept, one per cycle, out_valid continuous, occupancy=1, stall_cnt=0.
- SKID=1: out_ready=0 for 3 cycles while in_valid=1 → first entry held on outputs; second entry captured in skid; in_ready=0 from the next cycle; occupancy=2; stall_cnt=3. Release out_ready → outputs yield entry 1, then 2, then 3, in order.
- Flush asserted with occupancy=2 and accept in the same cycle → next cycle out_valid=0, out_ir=NOP, out_pc=0, occupancy=0, in_ready=1, stall_cnt unchanged.
- Reset asserted mid-stream with occupancy=2 and in_valid=1 → next cycle all outputs at reset values, stall_cnt=0; the incoming entry does not appear later.
- CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt saturates at 15.
- SKID=0: out_ready=0 with out_valid=1 → in_ready=0 combinationally. Raise out_ready in the same cycle as in_valid → in_ready=1, pop and accept together, new entry on outputs next cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Purpose : parametrised inter-stage pipeline register with valid/ready handshake, optional skid entry, flush and stall counter.
// Latency : 1 cycle from accept to out_valid; one entry per cycle while out_ready is held high.
// Backpr. : SKID=1 drops in_ready (from a register) once the skid entry fills; SKID=0 derives in_ready combinationally from out_ready.
module pipe_stage_reg #(
   parameter int              IR_W  = 32,
   parameter int              PC_W  = 32,
   parameter int              EXT_W = 8,
   parameter logic [IR_W-1:0] NOP   = '0,
   parameter bit              SKID  = 1'b1,
   parameter int              CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IR_W-1:0]   in_ir,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [EXT_W-1:0]  in_ext,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IR_W-1:0]   out_ir,
   output logic [PC_W-1:0]   out_pc,
   output logic [EXT_W-1:0]  out_ext,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   // One pipeline entry: instruction, PC4 and sideband travel together.
   typedef struct packed {
      logic [IR_W-1:0]  ir;
      logic [PC_W-1:0]  pc;
      logic [EXT_W-1:0] ext;
   } entry_t;

   // Value held by an empty slot: a bubble shows NOP with zeroed PC and sideband.
   localparam entry_t EMPTY_ENT = '{ir: NOP, pc: '0, ext: '0};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             out_v_q, out_v_d;
   entry_t           out_q, out_d;
   logic             skid_v_q, skid_v_d;
   entry_t           skid_q, skid_d;
   logic [1:0]       occ_q, occ_d;
   logic [CNT_W-1:0] cnt_q;

   logic   accept;
   logic   pop;
   logic   stall;
   entry_t in_ent;

   assign in_ent = '{ir: in_ir, pc: in_pc, ext: in_ext};

   // With a skid slot, in_ready depends only on registered state so out_ready never reaches it;
   // without one, a pop in the same cycle frees the single register for the incoming entry.
   generate
      if (SKID) begin : g_skid_rdy
         assign in_ready = ~skid_v_q;
      end else begin : g_flow_rdy
         assign in_ready = ~out_v_q | out_ready;
      end
   endgenerate

   assign accept = in_valid & in_ready;
   assign pop    = out_v_q & out_ready;
   assign stall  = out_v_q & ~out_ready;

   // Next-state for output and skid slots: flush empties both, otherwise FIFO-order refill.
   always_comb begin
      out_v_d  = out_v_q;
      out_d    = out_q;
      skid_v_d = skid_v_q;
      skid_d   = skid_q;
      if (flush) begin
         out_v_d  = 1'b0;
         out_d    = EMPTY_ENT;
         skid_v_d = 1'b0;
         skid_d   = EMPTY_ENT;
      end else if (!out_v_q || pop) begin
         if (SKID && skid_v_q) begin
            // Older skid entry moves forward first; a simultaneous accept takes its place.
            out_v_d  = 1'b1;
            out_d    = skid_q;
            skid_v_d = accept;
            skid_d   = accept ? in_ent : EMPTY_ENT;
         end else if (accept) begin
            out_v_d = 1'b1;
            out_d   = in_ent;
         end else begin
            out_v_d = 1'b0;
            out_d   = EMPTY_ENT;
         end
      end else if (SKID && accept) begin
         // Output is blocked; park the incoming entry (skid is known empty since in_ready was high).
         skid_v_d = 1'b1;
         skid_d   = in_ent;
      end
      occ_d = {1'b0, out_v_d} + {1'b0, skid_v_d};
   end

   // Entry storage and registered occupancy; reset discards everything including this cycle's accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_v_q  <= 1'b0;
         out_q    <= EMPTY_ENT;
         skid_v_q <= 1'b0;
         skid_q   <= EMPTY_ENT;
         occ_q    <= 2'd0;
      end else begin
         out_v_q  <= out_v_d;
         out_q    <= out_d;
         skid_v_q <= SKID ? skid_v_d : 1'b0;
         skid_q   <= SKID ? skid_d : EMPTY_ENT;
         occ_q    <= occ_d;
      end
   end

   // Saturating count of cycles where a held entry was refused downstream; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (stall && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign out_valid = out_v_q;
   assign out_ir    = out_q.ir;
   assign out_pc    = out_q.pc;
   assign out_ext   = out_q.ext;
   assign occupancy = occ_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid variant with a 4-bit stall counter and a no-skid variant.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// Expected values are hand-computed per scenario step.
module tb_pipe_stage_reg;

   localparam logic [31:0] NOPV = 32'h0000_0013;

   logic clk;
   logic reset;

   // Instance A: SKID=1, CNT_W=4
   logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0] a_in_ir, a_in_pc, a_out_ir, a_out_pc;
   logic [7:0]  a_in_ext, a_out_ext;
   logic [1:0]  a_occ;
   logic [3:0]  a_stall;

   // Instance B: SKID=0, CNT_W=16
   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0] b_in_ir, b_in_pc, b_out_ir, b_out_pc;
   logic [7:0]  b_in_ext, b_out_ext;
   logic [1:0]  b_occ;
   logic [15:0] b_stall;

   int n_cmp = 0;
   int n_bad = 0;

   pipe_stage_reg #(.IR_W(32), .PC_W(32), .EXT_W(8), .NOP(NOPV), .SKID(1'b1), .CNT_W(4)) dut_a (
      .clk(clk), .reset(reset), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_ir(a_in_ir), .in_pc(a_in_pc), .in_ext(a_in_ext),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_ir(a_out_ir), .out_pc(a_out_pc), .out_ext(a_out_ext),
      .occupancy(a_occ), .stall_cnt(a_stall)
   );

   pipe_stage_reg #(.IR_W(32), .PC_W(32), .EXT_W(8), .NOP(NOPV), .SKID(1'b0), .CNT_W(16)) dut_b (
      .clk(clk), .reset(reset), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_ir(b_in_ir), .in_pc(b_in_pc), .in_ext(b_in_ext),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_ir(b_out_ir), .out_pc(b_out_pc), .out_ext(b_out_ext),
      .occupancy(b_occ), .stall_cnt(b_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [31:0] ir, input logic [31:0] pc, input logic [7:0] ext, input logic rdy);
      a_in_valid  = v;
      a_in_ir     = ir;
      a_in_pc     = pc;
      a_in_ext    = ext;
      a_out_ready = rdy;
   endtask

   task automatic check_a_out(input string tag, input logic v, input logic [31:0] ir, input logic [31:0] pc, input logic [1:0] occ);
      check({tag, ".valid"}, a_out_valid, v);
      check({tag, ".ir"}, a_out_ir, ir);
      check({tag, ".pc"}, a_out_pc, pc);
      check({tag, ".occ"}, a_occ, occ);
   endtask

   initial begin
      reset = 1'b1;
      a_flush = 1'b0; drive_a(1'b0, '0, '0, '0, 1'b0);
      b_flush = 1'b0; b_in_valid = 1'b0; b_in_ir = '0; b_in_pc = '0; b_in_ext = '0; b_out_ready = 1'b0;
      step();
      step();

      // Reset state of both instances
      check_a_out("a_rst", 1'b0, NOPV, 32'h0, 2'd0);
      check("a_rst.ext", a_out_ext, 8'h00);
      check("a_rst.stall", a_stall, 4'd0);
      check("a_rst.in_ready", a_in_ready, 1'b1);
      check("b_rst.valid", b_out_valid, 1'b0);
      check("b_rst.ir", b_out_ir, NOPV);
      check("b_rst.in_ready", b_in_ready, 1'b1);
      reset = 1'b0;

      // Streaming with out_ready=1: each entry appears one cycle after its accept
      for (int k = 0; k < 5; k++) begin
         drive_a(1'b1, 32'h1000_0001 + k, 32'h3004 + 4 * k, 8'(k + 1), 1'b1);
         step();
         check_a_out($sformatf("a_strm%0d", k), 1'b1, 32'h1000_0001 + k, 32'h3004 + 4 * k, 2'd1);
         check($sformatf("a_strm%0d.ext", k), a_out_ext, 8'(k + 1));
         check($sformatf("a_strm%0d.stall", k), a_stall, 4'd0);
      end
      drive_a(1'b0, '0, '0, '0, 1'b1);
      step();
      check_a_out("a_drain", 1'b0, NOPV, 32'h0, 2'd0);

      // Stall with skid: E1 held, E2 parked in skid, E3 refused
      drive_a(1'b1, 32'h2000_0001, 32'h4004, 8'h11, 1'b0);
      step();
      check_a_out("a_st1", 1'b1, 32'h2000_0001, 32'h4004, 2'd1);
      check("a_st1.stall", a_stall, 4'd0);
      drive_a(1'b1, 32'h2000_0002, 32'h4008, 8'h12, 1'b0);
      step();
      check_a_out("a_st2", 1'b1, 32'h2000_0001, 32'h4004, 2'd2);
      check("a_st2.in_ready", a_in_ready, 1'b0);
      check("a_st2.stall", a_stall, 4'd1);
      drive_a(1'b1, 32'h2000_0003, 32'h400C, 8'h13, 1'b0);
      step();
      step();
      check_a_out("a_st4", 1'b1, 32'h2000_0001, 32'h4004, 2'd2);
      check("a_st4.ext", a_out_ext, 8'h11);
      check("a_st4.stall", a_stall, 4'd3);
      // Release: E1 consumed, E2 from skid, then E3 accepted
      a_out_ready = 1'b1;
      step();
      check_a_out("a_rel1", 1'b1, 32'h2000_0002, 32'h4008, 2'd1);
      check("a_rel1.in_ready", a_in_ready, 1'b1);
      check("a_rel1.stall", a_stall, 4'd3);
      step();
      check_a_out("a_rel2", 1'b1, 32'h2000_0003, 32'h400C, 2'd1);
      check("a_rel2.ext", a_out_ext, 8'h13);
      drive_a(1'b0, '0, '0, '0, 1'b1);
      step();
      check_a_out("a_rel3", 1'b0, NOPV, 32'h0, 2'd0);

      // Flush with occupancy=2 and an offered entry
      drive_a(1'b1, 32'h3000_0001, 32'h5004, 8'h21, 1'b0);
      step();
      drive_a(1'b1, 32'h3000_0002, 32'h5008, 8'h22, 1'b0);
      step();
      check_a_out("a_fl_pre", 1'b1, 32'h3000_0001, 32'h5004, 2'd2);
      check("a_fl_pre.stall", a_stall, 4'd4);
      a_flush = 1'b1;
      drive_a(1'b1, 32'h3000_0003, 32'h500C, 8'h23, 1'b1);
      step();
      check_a_out("a_fl", 1'b0, NOPV, 32'h0, 2'd0);
      check("a_fl.in_ready", a_in_ready, 1'b1);
      check("a_fl.stall", a_stall, 4'd4);
      a_flush = 1'b0;
      drive_a(1'b0, '0, '0, '0, 1'b1);
      step();
      check_a_out("a_fl_post", 1'b0, NOPV, 32'h0, 2'd0);

      // Reset mid-stream with occupancy=2 and an offered entry
      drive_a(1'b1, 32'h4000_0001, 32'h6004, 8'h31, 1'b0);
      step();
      drive_a(1'b1, 32'h4000_0002, 32'h6008, 8'h32, 1'b0);
      step();
      check("a_mr_pre.occ", a_occ, 2'd2);
      check("a_mr_pre.stall", a_stall, 4'd5);
      reset = 1'b1;
      drive_a(1'b1, 32'h4000_0003, 32'h600C, 8'h33, 1'b0);
      step();
      check_a_out("a_mr", 1'b0, NOPV, 32'h0, 2'd0);
      check("a_mr.stall", a_stall, 4'd0);
      check("a_mr.in_ready", a_in_ready, 1'b1);
      reset = 1'b0;
      drive_a(1'b0, '0, '0, '0, 1'b1);
      step();
      check_a_out("a_mr_post", 1'b0, NOPV, 32'h0, 2'd0);

      // Saturation of the 4-bit stall counter
      drive_a(1'b1, 32'h5000_0001, 32'h7004, 8'h41, 1'b0);
      step();
      a_in_valid = 1'b0;
      for (int c = 0; c < 10; c++) step();
      check("a_sat10.stall", a_stall, 4'd10);
      for (int c = 0; c < 10; c++) step();
      check("a_sat20.stall", a_stall, 4'd15);
      check_a_out("a_sat.hold", 1'b1, 32'h5000_0001, 32'h7004, 2'd1);

      // SKID=0: combinational in_ready, pop and accept in the same cycle
      b_in_valid = 1'b1; b_in_ir = 32'h6000_0001; b_in_pc = 32'h8004; b_in_ext = 8'h51; b_out_ready = 1'b0;
      step();
      check("b_k1.valid", b_out_valid, 1'b1);
      check("b_k1.ir", b_out_ir, 32'h6000_0001);
      b_in_ir = 32'h6000_0002; b_in_pc = 32'h8008; b_in_ext = 8'h52;
      #1;
      check("b_k1.in_ready", b_in_ready, 1'b0);
      step();
      check("b_hold.ir", b_out_ir, 32'h6000_0001);
      check("b_hold.occ", b_occ, 2'd1);
      check("b_hold.stall", b_stall, 16'd1);
      b_out_ready = 1'b1;
      #1;
      check("b_rdy.in_ready", b_in_ready, 1'b1);
      step();
      check("b_k2.valid", b_out_valid, 1'b1);
      check("b_k2.ir", b_out_ir, 32'h6000_0002);
      check("b_k2.pc", b_out_pc, 32'h8008);
      check("b_k2.occ", b_occ, 2'd1);
      b_in_valid = 1'b0;
      step();
      check("b_end.valid", b_out_valid, 1'b0);
      check("b_end.ir", b_out_ir, NOPV);
      check("b_end.occ", b_occ, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
